outbound_msg_scheduler: RTL and testbench
=========================================

// Module: outbound_msg_scheduler
// PURPOSE
//  Arbitrates the single outbound message-creation path (create_message -> fsm_msg_create_2
//  -> interface_controller_in) among NUM_REQ requesters: session manager, heartbeat timer,
//  application orders. Grants round-robin, issues one initiate pulse with type and host,
//  then holds off until the message is fully sent. Sits between requesters and the
//  create_message start_i/message_type_i inputs.
// PARAMETERS
//  NUM_REQ     3     number of requesters (>=2)
//  NUM_HOST    `HOST_ADDR_WIDTH  host address width
//  GAP_CYCLES  2     idle cycles enforced after each message (0 allowed)
//  TIMEOUT     1024  watchdog limit in cycles (used only with watchdog macro)
// PORTS
//  clk           in   1               clock
//  rst           in   1               synchronous reset, active high
//  req_i         in   NUM_REQ         request per requester, level, held until grant
//  req_type_i    in   4*NUM_REQ       message type per requester (slice i = [4i+3:4i])
//  req_host_i    in   NUM_HOST*NUM_REQ  target host per requester
//  fifo_full_i   in   1               outbound fifo full
//  all_sent_i    in   1               pulse: current message fully written to fifo
//  grant_o       out  NUM_REQ         one-hot, one-cycle grant pulse
//  initiate_msg_o out 1               one-cycle start pulse to create_message
//  message_type_o out 4               type of message in flight
//  host_addr_o   out  NUM_HOST        host of message in flight
//  busy_o        out  1               high outside IDLE
//  timeout_o     out  1               one-cycle watchdog abort pulse
// BEHAVIOUR
//  - One clock, sync active-high reset. Reset: all outputs 0, state IDLE, rr pointer 0,
//    counters 0. Reset mid-message abandons it; no grant/initiate is re-issued.
//  - FSM: IDLE -> WAIT_DONE -> GAP -> IDLE (GAP skipped when GAP_CYCLES==0).
//  - IDLE: if |req_i and !fifo_full_i, winner = first set req at or after rr pointer
//    (wrapping). At that clock edge register: grant_o[winner]=1, initiate_msg_o=1,
//    message_type_o/host_addr_o = winner's slices, rr = (winner+1) mod NUM_REQ,
//    state -> WAIT_DONE. Latency req->grant/initiate: 1 cycle. fifo_full_i high: no issue.
//  - grant_o and initiate_msg_o are high exactly one cycle, always together.
//  - message_type_o/host_addr_o hold from initiate until the next grant (not cleared).
//  - WAIT_DONE: req_i ignored; all_sent_i -> GAP (or IDLE if GAP_CYCLES==0).
//  - GAP: count GAP_CYCLES cycles, then IDLE. Re-arbitration can first grant on
//    the edge after GAP ends.
//  - all_sent_i outside WAIT_DONE is ignored.
//  - Requester must deassert req_i the cycle after its grant; a req still high then is
//    treated as a new request (grant only after GAP).
//  - busy_o = (state != IDLE), registered with the state.
// CONFIGURATION
//  `MSG_SCHED_WATCHDOG_EN defined: in WAIT_DONE a counter increments each cycle
//    fifo_full_i is low (frozen while full). If it reaches TIMEOUT without all_sent_i:
//    timeout_o pulses 1 cycle, state -> GAP. all_sent_i in the same cycle as the limit
//    wins, with no timeout. Counter clears on entry to WAIT_DONE.
//  Not defined: no counter; WAIT_DONE waits indefinitely; timeout_o tied 0.
// TESTING
//  1 Reset: rst=1 for 2 cycles with req_i=3'b111 -> all outputs 0. Then release:
//    grant_o=001 and initiate 1 cycle after release.
//  2 Round-robin: req_i=111 held, all_sent_i pulsed 5 cycles after each initiate,
//    GAP_CYCLES=2 -> grant order 001,010,100,001, consecutive grants >=8 cycles apart.
//  3 Back-pressure: fifo_full_i=1, req_i=010 -> no grant for 20 cycles. Deassert full ->
//    grant_o=010 next edge; message_type_o=req_type_i[7:4], host_addr_o=req_host_i slice 1.
//  4 Stray/simultaneous: all_sent_i in IDLE -> no change. Requests 100 and 001 arriving in
//    the same cycle with rr=2 -> 100 granted first.
//  5 Mid-op reset: rst during WAIT_DONE -> next cycle busy_o=0, rr=0. No initiate until
//    a request is seen after reset.
//  6 Watchdog (MSG_SCHED_WATCHDOG_EN, TIMEOUT=16): no all_sent_i, fifo_full_i high 4 cycles
//    -> timeout_o pulses on cycle 20 after initiate. Without the macro -> stays busy,
//    timeout_o=0.

Source files
------------

// File: rtl/outbound_msg_scheduler_if.sv
// ============================================================================
// Module   : outbound_msg_scheduler_if
// Purpose  : Requester/scheduler bundle for the outbound message-creation path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef HOST_ADDR_WIDTH
`define HOST_ADDR_WIDTH 8
`endif

interface outbound_msg_scheduler_if #(
    parameter int NUM_REQ  = 3,
    parameter int NUM_HOST = `HOST_ADDR_WIDTH
);
    logic [NUM_REQ-1:0]          req;
    logic [4*NUM_REQ-1:0]        req_type;
    logic [NUM_HOST*NUM_REQ-1:0] req_host;
    logic                        fifo_full;
    logic                        all_sent;
    logic [NUM_REQ-1:0]          grant;
    logic                        initiate_msg;
    logic [3:0]                  message_type;
    logic [NUM_HOST-1:0]         host_addr;
    logic                        busy;
    logic                        timeout;

    modport master (
        output req, req_type, req_host, fifo_full, all_sent,
        input  grant, initiate_msg, message_type, host_addr, busy, timeout
    );

    modport slave (
        input  req, req_type, req_host, fifo_full, all_sent,
        output grant, initiate_msg, message_type, host_addr, busy, timeout
    );
endinterface

`default_nettype wire

// File: rtl/outbound_msg_scheduler.sv
// ============================================================================
// Module   : outbound_msg_scheduler
// Purpose  : Round-robin arbiter issuing one create_message start per grant,
//            holding off until all_sent plus an idle gap. Optional watchdog
//            enabled by defining MSG_SCHED_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef HOST_ADDR_WIDTH
`define HOST_ADDR_WIDTH 8
`endif

module outbound_msg_scheduler #(
    parameter int NUM_REQ    = 3,
    parameter int NUM_HOST   = `HOST_ADDR_WIDTH,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  wire logic               clk,
    input  wire logic               rst,
    outbound_msg_scheduler_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT_DONE = 2'd1;
    localparam logic [1:0] c_GAP       = 2'd2;

    if (NUM_REQ < 2 || TIMEOUT < 1) begin : g_param_check
        $error("outbound_msg_scheduler: NUM_REQ must be >= 2 and TIMEOUT >= 1");
    end

    logic [1:0]          r_state, w_state_nxt;
    logic [PTR_W-1:0]    r_rr, w_rr_nxt;
    logic [GAP_W-1:0]    r_gap_cnt, w_gap_cnt_nxt;
    logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;
    logic                r_initiate, w_initiate_nxt;
    logic [3:0]          r_type, w_type_nxt;
    logic [NUM_HOST-1:0] r_host, w_host_nxt;
    logic                r_timeout, w_timeout_nxt;
    logic                r_busy;
    logic                w_found, w_issue, w_expire;
    logic [PTR_W-1:0]    w_winner, w_cand;
    int                  w_sum;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        w_sum    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = int'(r_rr) + k;
            if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
            w_cand = PTR_W'(w_sum);
            if (!w_found && bus.req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_issue = (r_state == c_IDLE) && w_found && !bus.fifo_full;

`ifdef MSG_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] r_wd_cnt;

    // Held at zero outside WAIT_DONE, so it is clear on every entry.
    always_ff @(posedge clk) begin
        if (rst || r_state != c_WAIT_DONE) begin
            r_wd_cnt <= '0;
        end else if (!bus.fifo_full) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

    assign w_expire = (r_state == c_WAIT_DONE) && !bus.all_sent && !bus.fifo_full
                      && (int'(r_wd_cnt) == TIMEOUT - 1);
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_rr       <= '0;
            r_gap_cnt  <= '0;
            r_grant    <= '0;
            r_initiate <= 1'b0;
            r_type     <= '0;
            r_host     <= '0;
            r_timeout  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr       <= w_rr_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_grant    <= w_grant_nxt;
            r_initiate <= w_initiate_nxt;
            r_type     <= w_type_nxt;
            r_host     <= w_host_nxt;
            r_timeout  <= w_timeout_nxt;
            r_busy     <= (w_state_nxt != c_IDLE);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gap_cnt_nxt = '0;
        case (r_state)
            c_IDLE: begin
                if (w_issue) w_state_nxt = c_WAIT_DONE;
            end
            c_WAIT_DONE: begin
                if (bus.all_sent || w_expire)
                    w_state_nxt = (GAP_CYCLES == 0) ? c_IDLE : c_GAP;
            end
            c_GAP: begin
                if (int'(r_gap_cnt) >= GAP_CYCLES - 1) w_state_nxt = c_IDLE;
                else                                   w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Type/host are only reloaded on a grant so they persist for the whole message.
    always_comb begin
        w_grant_nxt    = '0;
        w_initiate_nxt = 1'b0;
        w_type_nxt     = r_type;
        w_host_nxt     = r_host;
        w_rr_nxt       = r_rr;
        w_timeout_nxt  = w_expire;
        if (w_issue) begin
            w_grant_nxt    = NUM_REQ'(1) << w_winner;
            w_initiate_nxt = 1'b1;
            w_rr_nxt       = (int'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + PTR_W'(1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_winner == PTR_W'(i)) begin
                    w_type_nxt = bus.req_type[4*i +: 4];
                    w_host_nxt = bus.req_host[NUM_HOST*i +: NUM_HOST];
                end
            end
        end
    end

    assign bus.grant        = r_grant;
    assign bus.initiate_msg = r_initiate;
    assign bus.message_type = r_type;
    assign bus.host_addr    = r_host;
    assign bus.busy         = r_busy;
    assign bus.timeout      = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_outbound_msg_scheduler.sv
// ============================================================================
// Module   : tb_outbound_msg_scheduler
// Purpose  : Directed scenarios plus random traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_outbound_msg_scheduler;
    localparam int NUM_REQ    = 3;
    localparam int NUM_HOST   = 8;
    localparam int GAP_CYCLES = 2;
    localparam int TIMEOUT    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    outbound_msg_scheduler_if #(.NUM_REQ(NUM_REQ), .NUM_HOST(NUM_HOST)) bus();

    outbound_msg_scheduler #(
        .NUM_REQ(NUM_REQ), .NUM_HOST(NUM_HOST),
        .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: a message is either awaiting all_sent, in its trailing gap, or done.
    int                  m_ptr, m_gap, m_wd;
    bit                  m_wait;
    logic [NUM_REQ-1:0]  e_grant;
    logic                e_init, e_busy, e_tmo;
    logic [3:0]          e_type;
    logic [NUM_HOST-1:0] e_host;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_ptr = 0; m_gap = 0; m_wd = 0; m_wait = 0;
            e_grant = '0; e_init = 0; e_type = '0; e_host = '0; e_busy = 0; e_tmo = 0;
            return;
        end
        e_grant = '0; e_init = 0; e_tmo = 0;
        if (m_wait) begin
            if (bus.all_sent) begin
                m_wait = 0;
                m_gap  = GAP_CYCLES;
            end
`ifdef MSG_SCHED_WATCHDOG_EN
            else begin
                if (!bus.fifo_full) m_wd++;
                if (m_wd >= TIMEOUT) begin
                    e_tmo = 1; m_wait = 0; m_gap = GAP_CYCLES;
                end
            end
`endif
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (bus.req != '0 && !bus.fifo_full) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int w;
                w = (m_ptr + k) % NUM_REQ;
                if (bus.req[w]) begin
                    e_grant = '0;
                    e_grant[w] = 1'b1;
                    e_init = 1;
                    e_type = bus.req_type[4*w +: 4];
                    e_host = bus.req_host[NUM_HOST*w +: NUM_HOST];
                    m_ptr  = (w + 1) % NUM_REQ;
                    m_wait = 1;
                    m_wd   = 0;
                    break;
                end
            end
        end
        e_busy = m_wait || (m_gap > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check_eq("grant",        32'(bus.grant),        32'(e_grant));
        check_eq("initiate",     32'(bus.initiate_msg), 32'(e_init));
        check_eq("message_type", 32'(bus.message_type), 32'(e_type));
        check_eq("host_addr",    32'(bus.host_addr),    32'(e_host));
        check_eq("busy",         32'(bus.busy),         32'(e_busy));
        check_eq("timeout",      32'(bus.timeout),      32'(e_tmo));
    endtask

    task automatic wait_grant(input string tag, input logic [NUM_REQ-1:0] exp);
        int k;
        k = 0;
        while (bus.grant == '0 && k < 40) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(bus.grant), 32'(exp));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 60) begin
            tick();
            k++;
        end
        if (bus.busy) check_eq("wait_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic pulse_sent();
        bus.all_sent = 1'b1;
        tick();
        bus.all_sent = 1'b0;
    endtask

    initial begin
        logic [NUM_REQ-1:0] rr_seq [4];
        logic [4*NUM_REQ-1:0]        t_types;
        logic [NUM_HOST*NUM_REQ-1:0] t_hosts;
        int last, c0, k;
        rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;

        bus.req = 3'b111; bus.fifo_full = 1'b0; bus.all_sent = 1'b0;
        bus.req_type = 12'h321; bus.req_host = 24'hC0B0A0;
        rst = 1'b1;

        // Reset with requests pending, then first grant one cycle after release
        repeat (2) tick();
        check_eq("rst_grant", 32'(bus.grant), 32'd0);
        check_eq("rst_busy",  32'(bus.busy),  32'd0);
        rst = 1'b0;
        tick();
        check_eq("release_grant", 32'(bus.grant), 32'(rr_seq[0]));
        check_eq("release_init",  32'(bus.initiate_msg), 32'd1);
        last = cyc;

        // Round-robin with req held and all_sent 5 cycles after each initiate
        for (int i = 1; i < 4; i++) begin
            repeat (4) tick();
            pulse_sent();
            wait_grant("rr_order", rr_seq[i]);
            check_eq("rr_spacing_ge8", 32'((cyc - last) >= 8), 32'd1);
            last = cyc;
        end
        bus.req = '0;
        pulse_sent();
        wait_idle();

        // Back-pressure: full blocks issue; release grants requester 1 with its slices
        t_types = 12'($urandom); t_hosts = 24'($urandom);
        bus.req_type = t_types; bus.req_host = t_hosts;
        bus.fifo_full = 1'b1; bus.req = 3'b010;
        repeat (20) begin
            tick();
            check_eq("bp_no_grant", 32'(bus.grant), 32'd0);
        end
        bus.fifo_full = 1'b0;
        tick();
        check_eq("bp_grant", 32'(bus.grant), 32'h2);
        check_eq("bp_type",  32'(bus.message_type), 32'(t_types[7:4]));
        check_eq("bp_host",  32'(bus.host_addr), 32'(t_hosts[15:8]));
        bus.req = '0;
        pulse_sent();
        wait_idle();

        // Stray all_sent in IDLE, then simultaneous 100/001 with pointer at 2
        bus.all_sent = 1'b1;
        tick();
        bus.all_sent = 1'b0;
        check_eq("stray_busy",  32'(bus.busy),  32'd0);
        check_eq("stray_grant", 32'(bus.grant), 32'd0);
        bus.req = 3'b101;
        tick();
        check_eq("simul_grant", 32'(bus.grant), 32'h4);
        bus.req = '0;
        pulse_sent();
        wait_idle();

        // Mid-message reset: pointer returns to 0, nothing re-issued without a request
        bus.req = 3'b001;
        tick();
        check_eq("pre_rst_grant", 32'(bus.grant), 32'h1);
        bus.req = '0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        repeat (5) begin
            tick();
            check_eq("midrst_no_init", 32'(bus.initiate_msg), 32'd0);
        end
        bus.req = 3'b011;
        tick();
        check_eq("rr_after_rst", 32'(bus.grant), 32'h1);
        c0 = cyc;
        bus.req = '0;

        // Watchdog: fifo_full freezes the count for 4 cycles
        bus.fifo_full = 1'b1;
        repeat (4) tick();
        bus.fifo_full = 1'b0;
        k = 0;
        while (!bus.timeout && k < 40) begin
            tick();
            k++;
        end
`ifdef MSG_SCHED_WATCHDOG_EN
        check_eq("wd_cycle", 32'(cyc - c0), 32'd20);
`else
        check_eq("no_wd_timeout", 32'(bus.timeout), 32'd0);
        check_eq("no_wd_busy",    32'(bus.busy),    32'd1);
        pulse_sent();
`endif
        wait_idle();

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            rst           = ($urandom_range(99) == 0);
            bus.req       = NUM_REQ'($urandom);
            bus.req_type  = 12'($urandom);
            bus.req_host  = 24'($urandom);
            bus.fifo_full = ($urandom_range(4) == 0);
            bus.all_sent  = ($urandom_range(5) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
